// File: rtl/fc_tx_credit_scheduler.sv
// Transmit-side flow-control credit gate with round-robin arbitration over the P/NP/CPL buffers.
// Optional build macro FC_INFINITE_CREDIT_EN: a zero limit received during FC init means infinite credit.
module fc_tx_credit_scheduler #(
   parameter int HDR_CW  = 8,
   parameter int DATA_CW = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fc_init_done,
   input  logic                 upd_valid,
   input  logic [1:0]           upd_type,
   input  logic [HDR_CW-1:0]    upd_hdr_cl,
   input  logic [DATA_CW-1:0]   upd_data_cl,
   input  logic [2:0]           req_valid,
   input  logic [3*DATA_CW-1:0] req_dc,
   input  logic                 tx_done,
   output logic [2:0]           gnt,
   output logic [2:0]           blocked,
   output logic [3*HDR_CW-1:0]  cc_hdr,
   output logic [3*DATA_CW-1:0] cc_data
);

   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_ARB  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam logic [HDR_CW-1:0]  HDR_HALF  = {1'b1, {(HDR_CW-1){1'b0}}};
   localparam logic [DATA_CW-1:0] DATA_HALF = {1'b1, {(DATA_CW-1){1'b0}}};

   logic [1:0]         state_q, state_d;
   logic [1:0]         rr_q, rr_d;
   logic [2:0]         gnt_q, gnt_d;
   logic [2:0]         blocked_q, blocked_d;
   logic [HDR_CW-1:0]  cl_hdr_q [3];
   logic [HDR_CW-1:0]  cl_hdr_d [3];
   logic [DATA_CW-1:0] cl_data_q [3];
   logic [DATA_CW-1:0] cl_data_d [3];
   logic [HDR_CW-1:0]  cc_hdr_q [3];
   logic [HDR_CW-1:0]  cc_hdr_d [3];
   logic [DATA_CW-1:0] cc_data_q [3];
   logic [DATA_CW-1:0] cc_data_d [3];

   logic [DATA_CW-1:0] dc [3];
   logic [HDR_CW-1:0]  hdr_room [3];
   logic [DATA_CW-1:0] data_room [3];
   logic [2:0]         hdr_ok, data_ok, eligible;
   logic [2:0]         cand;
   logic               win_found;
   logic [1:0]         win;

`ifdef FC_INFINITE_CREDIT_EN
   logic [2:0]         inf_hdr_q, inf_hdr_d;
   logic [2:0]         inf_data_q, inf_data_d;
`endif

   // Remaining window after this TLP, modulo counter width; at most half the range counts as "fits".
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         dc[c]        = req_dc[c*DATA_CW +: DATA_CW];
         hdr_room[c]  = cl_hdr_q[c] - (cc_hdr_q[c] + HDR_CW'(1));
         data_room[c] = cl_data_q[c] - (cc_data_q[c] + dc[c]);
         hdr_ok[c]    = (hdr_room[c] <= HDR_HALF);
         data_ok[c]   = (dc[c] == '0) || (data_room[c] <= DATA_HALF);
`ifdef FC_INFINITE_CREDIT_EN
         hdr_ok[c]    = hdr_ok[c] | inf_hdr_q[c];
         data_ok[c]   = data_ok[c] | inf_data_q[c];
`endif
         eligible[c]  = req_valid[c] & hdr_ok[c] & data_ok[c];
      end
   end

   always_comb begin
      win_found = 1'b0;
      win       = 2'd0;
      cand      = 3'd0;
      for (int i = 0; i < 3; i++) begin
         cand = {1'b0, rr_q} + 3'(i);
         if (cand >= 3'd3) begin
            cand = cand - 3'd3;
         end
         if (!win_found && eligible[cand[1:0]]) begin
            win_found = 1'b1;
            win       = cand[1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gnt_d     = 3'b000;
      blocked_d = (state_q == S_INIT) ? 3'b000 : (req_valid & ~(hdr_ok & data_ok));
      for (int c = 0; c < 3; c++) begin
         cl_hdr_d[c]  = cl_hdr_q[c];
         cl_data_d[c] = cl_data_q[c];
         cc_hdr_d[c]  = cc_hdr_q[c];
         cc_data_d[c] = cc_data_q[c];
      end
`ifdef FC_INFINITE_CREDIT_EN
      inf_hdr_d  = inf_hdr_q;
      inf_data_d = inf_data_q;
`endif

      case (state_q)
         S_INIT: begin
            if (fc_init_done) begin
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            if (win_found) begin
               state_d = S_WAIT;
               rr_d    = (win == 2'd2) ? 2'd0 : win + 2'd1;
               for (int c = 0; c < 3; c++) begin
                  if (win == 2'(c)) begin
                     gnt_d[c]     = 1'b1;
                     cc_hdr_d[c]  = cc_hdr_q[c] + HDR_CW'(1);
                     cc_data_d[c] = cc_data_q[c] + dc[c];
                  end
               end
            end
         end
         S_WAIT: begin
            if (tx_done) begin
               state_d = S_ARB;
            end
         end
         default: state_d = S_INIT;
      endcase

      // Limits are overwritten, not accumulated; the grant decision above already used the old value.
      for (int c = 0; c < 3; c++) begin
         if (upd_valid && (upd_type == 2'(c))) begin
            cl_hdr_d[c]  = upd_hdr_cl;
            cl_data_d[c] = upd_data_cl;
`ifdef FC_INFINITE_CREDIT_EN
            if (state_q == S_INIT) begin
               inf_hdr_d[c]  = (upd_hdr_cl == '0);
               inf_data_d[c] = (upd_data_cl == '0);
            end
`endif
         end
      end

      // Link dropped: behave as a fresh FC initialization.
      if ((state_q != S_INIT) && !fc_init_done) begin
         state_d   = S_INIT;
         rr_d      = 2'd0;
         gnt_d     = 3'b000;
         blocked_d = 3'b000;
         for (int c = 0; c < 3; c++) begin
            cl_hdr_d[c]  = '0;
            cl_data_d[c] = '0;
            cc_hdr_d[c]  = '0;
            cc_data_d[c] = '0;
         end
`ifdef FC_INFINITE_CREDIT_EN
         inf_hdr_d  = 3'b000;
         inf_data_d = 3'b000;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_INIT;
         rr_q      <= 2'd0;
         gnt_q     <= 3'b000;
         blocked_q <= 3'b000;
         for (int c = 0; c < 3; c++) begin
            cl_hdr_q[c]  <= '0;
            cl_data_q[c] <= '0;
            cc_hdr_q[c]  <= '0;
            cc_data_q[c] <= '0;
         end
`ifdef FC_INFINITE_CREDIT_EN
         inf_hdr_q  <= 3'b000;
         inf_data_q <= 3'b000;
`endif
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         gnt_q     <= gnt_d;
         blocked_q <= blocked_d;
         for (int c = 0; c < 3; c++) begin
            cl_hdr_q[c]  <= cl_hdr_d[c];
            cl_data_q[c] <= cl_data_d[c];
            cc_hdr_q[c]  <= cc_hdr_d[c];
            cc_data_q[c] <= cc_data_d[c];
         end
`ifdef FC_INFINITE_CREDIT_EN
         inf_hdr_q  <= inf_hdr_d;
         inf_data_q <= inf_data_d;
`endif
      end
   end

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         cc_hdr[c*HDR_CW +: HDR_CW]    = cc_hdr_q[c];
         cc_data[c*DATA_CW +: DATA_CW] = cc_data_q[c];
      end
   end

   assign gnt     = gnt_q;
   assign blocked = blocked_q;

endmodule

// File: doc/fc_tx_credit_scheduler.md
Name: fc_tx_credit_scheduler

Overview:
- Transmit-side flow-control gate and arbiter for the transaction layer.
- Sits between the three per-class transaction pending buffers (Posted, Non-Posted, Completion) and the TLP transmitter.
- Tracks credit limits (CL) received via InitFC/UpdateFC and credits consumed (CC) per class and credit type.
- Round-robin grants one class at a time, only when the head TLP fits within the advertised credits.
- The grant pulse drives the winning buffer's rd_en.

Parameters:
- HDR_CW, 8, header credit counter width (modulo 2^HDR_CW arithmetic).
- DATA_CW, 12, data credit counter width (modulo 2^DATA_CW arithmetic).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fc_init_done  in  1  FC initialization complete for the link; low = link not initialized
- upd_valid  in  1  credit-limit update strobe (InitFC/UpdateFC decoded)
- upd_type  in  2  0=P, 1=NP, 2=CPL; 3 is ignored
- upd_hdr_cl  in  HDR_CW  new header credit limit
- upd_data_cl  in  DATA_CW  new data credit limit
- req_valid  in  3  per-class head-TLP present (buffer !empty); bit0=P, bit1=NP, bit2=CPL
- req_dc  in  3*DATA_CW  data credits of each class's head TLP; slice c = class c; 0 = no payload
- tx_done  in  1  transmitter finished the granted TLP (1-cycle pulse)
- gnt  out  3  one-hot grant pulse, 1 cycle
- blocked  out  3  class has a request but fails the credit check
- cc_hdr  out  3*HDR_CW  header credits consumed per class
- cc_data  out  3*DATA_CW  data credits consumed per class

Behaviour:
- Reset, synchronous: state=S_INIT; gnt=0; blocked=0; all CC=0; all CL=0; round-robin pointer=P.
- CL registers:
  - upd_valid loads CL_hdr[upd_type] and CL_data[upd_type] on the next edge, in any state except reset.
  - Updates overwrite; they do not accumulate.
- Credit check for class c, combinational:
  - hdr_ok = ((CL_hdr - (CC_hdr + 1)) mod 2^HDR_CW) <= 2^(HDR_CW-1).
  - data_ok = (req_dc == 0) or ((CL_data - (CC_data + req_dc)) mod 2^DATA_CW) <= 2^(DATA_CW-1).
  - eligible[c] = req_valid[c] & hdr_ok & data_ok.
- blocked[c] = registered (req_valid[c] & ~(hdr_ok & data_ok)), valid in S_ARB and S_WAIT, 0 in S_INIT.
- FSM:
  - S_INIT: gnt=0. Move to S_ARB when fc_init_done=1.
  - S_ARB: if any eligible, pick the first eligible class starting at the RR pointer (order P, NP, CPL, wrapping). The same edge:
    - asserts gnt[win] for exactly 1 cycle;
    - sets CC_hdr[win] += 1 and CC_data[win] += req_dc[win], both with modulo wrap;
    - moves the RR pointer to win+1;
    - goes to S_WAIT.
    - If nothing is eligible, stay in S_ARB.
  - S_WAIT: gnt=0. On tx_done, go to S_ARB.
- Latency:
  - eligible sampled at cycle N → gnt high in cycle N+1.
  - tx_done at cycle M → earliest next gnt at cycle M+2.
- Simultaneous upd_valid and grant decision in the same cycle: the check uses the old CL; the new CL applies from the next cycle.
- tx_done outside S_WAIT is ignored.
- Counter wrap: CC wraps modulo width; the check remains correct across wrap.
- fc_init_done falling in any non-INIT state: next edge goes to S_INIT, gnt=0, all CC and CL cleared, RR pointer=P. This models link re-initialization.
- req_valid dropping while in S_WAIT has no effect; the grant is already committed.

Optional Feature:
- FC_INFINITE_CREDIT_EN
- Defined:
  - Per class and type, an inf flag is set when upd_valid arrives in S_INIT with a limit value of 0 for that type.
  - inf forces hdr_ok (or data_ok) to 1.
  - CC still counts.
  - Updates received in S_ARB/S_WAIT do not change inf.
  - inf is cleared on rst or on return to S_INIT.
- Not defined: a limit of 0 is literal, so that class/type is blocked until a nonzero update arrives.

Test Plan:
- Reset/INIT: rst high 2 cycles, req_valid=3'b111, fc_init_done=0 → gnt=0, cc_hdr=cc_data=0, blocked=0 for 20 cycles.
- P credit exhaustion:
  - Stimulus: upd P hdr=4, data=16; req_dc[P]=4; tx_done 3 cycles after each gnt.
  - Response: exactly 4 gnt[0] pulses; cc_hdr[P]=4, cc_data[P]=16; then blocked[0]=1.
  - Then upd P hdr=5, data=20 → one more gnt[0]; cc_hdr[P]=5, cc_data[P]=20.
- Round robin: all classes given CL 100/1000, req_valid=3'b111, req_dc=2 → gnt sequence P, NP, CPL, P, NP; each class CC advances by 1 header and 2 data credits per grant.
- Wrap:
  - Stimulus: drive cc_hdr[NP] to 0xFE via grants, upd NP hdr=0x02.
  - Response: grants continue, cc_hdr[NP] goes 0xFF → 0x00 → 0x01 → 0x02, then blocked[1]=1.
- Re-init and collision:
  - fc_init_done dropped in S_WAIT → next cycle gnt=0, all CC=0, FSM in S_INIT.
  - Separately: upd_valid coinciding with a decision → decision uses the old CL.
- FC_INFINITE_CREDIT_EN:
  - Defined: InitFC CPL hdr=0, data=0 → 300 CPL grants with req_dc=16; cc_hdr[CPL]=300 mod 256=44, cc_data[CPL]=4800 mod 4096=704.
  - Undefined: same stimulus → no gnt[2], blocked[2]=1.
